// File: rtl/mult_arb_if.sv
// mult_arb_if: port set between the mult_arb sequencer and the shared
// 8x8 shift-add multiplier (start/busy handshake, 16-bit result).
// master = arbiter side, slave = multiplier side.
interface mult_arb_if;
  logic        mult_start_o;
  logic [7:0]  mult_a_bo;
  logic [7:0]  mult_b_bo;
  logic        mult_busy_i;
  logic [15:0] mult_y_bi;

  modport master (
    output mult_start_o,
    output mult_a_bo,
    output mult_b_bo,
    input  mult_busy_i,
    input  mult_y_bi
  );

  modport slave (
    input  mult_start_o,
    input  mult_a_bo,
    input  mult_b_bo,
    output mult_busy_i,
    output mult_y_bi
  );
endinterface

// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter/sequencer sharing one 8x8 multiplier between
// NREQ requesters. Grants one pending request, latches its operands, runs the
// multiplier through its start/busy handshake and returns the product with a
// one-cycle done pulse to the winner.
// Optional feature: define MULT_ARB_ZERO_BYPASS_EN to answer requests with a
// zero operand directly (one-cycle latency, multiplier not started).
module mult_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*8-1:0]  a_bi,
  input  logic [NREQ*8-1:0]  b_bi,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic [15:0]        y_bo,
  output logic               busy_o,
  mult_arb_if.master         mult
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
`ifdef MULT_ARB_ZERO_BYPASS_EN
    , ST_ZERO = 2'd3
`endif
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  win_reg;
  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] req_upper;
  logic [IDW-1:0]  win_next;
  logic [IDW-1:0]  ptr_adv;
  logic [7:0]      a_sel;
  logic [7:0]      b_sel;
  logic            any_req;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic            zero_op;
`endif

  // Requesters at or above the pointer get first pick; the rest wrap around.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign upper_mask[gi] = (IDW'(gi) >= ptr_reg);
    end
  endgenerate

  assign req_upper = req_i & upper_mask;
  assign any_req   = |req_i;

  // Winner: lowest set bit at/above the pointer, else lowest set bit overall.
  always_comb begin
    win_next = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) win_next = IDW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_upper[i]) win_next = IDW'(i);
    end
  end

  assign a_sel   = a_bi[{win_next, 3'b000} +: 8];
  assign b_sel   = b_bi[{win_next, 3'b000} +: 8];
  assign ptr_adv = (win_reg == IDW'(NREQ - 1)) ? '0 : win_reg + 1'b1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_op = (a_sel == 8'd0) || (b_sel == 8'd0);
`endif

  assign busy_o = (state_reg != ST_IDLE);

  // Sequencer FSM: arbitrate, launch the multiplier, collect the result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg         <= ST_IDLE;
      ptr_reg           <= '0;
      win_reg           <= '0;
      gnt_o             <= '0;
      done_o            <= '0;
      y_bo              <= '0;
      mult.mult_start_o <= 1'b0;
      mult.mult_a_bo    <= '0;
      mult.mult_b_bo    <= '0;
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            gnt_o          <= ONE_HOT0 << win_next;
            win_reg        <= win_next;
            mult.mult_a_bo <= a_sel;
            mult.mult_b_bo <= b_sel;
`ifdef MULT_ARB_ZERO_BYPASS_EN
            if (zero_op) begin
              state_reg <= ST_ZERO;
            end else begin
              mult.mult_start_o <= 1'b1;
              state_reg         <= ST_LAUNCH;
            end
`else
            mult.mult_start_o <= 1'b1;
            state_reg         <= ST_LAUNCH;
`endif
          end
        end
        ST_LAUNCH: begin
          if (mult.mult_busy_i) begin
            mult.mult_start_o <= 1'b0;
            state_reg         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!mult.mult_busy_i) begin
            y_bo      <= mult.mult_y_bi;
            done_o    <= ONE_HOT0 << win_reg;
            ptr_reg   <= ptr_adv;
            state_reg <= ST_IDLE;
          end
        end
`ifdef MULT_ARB_ZERO_BYPASS_EN
        ST_ZERO: begin
          y_bo      <= '0;
          done_o    <= ONE_HOT0 << win_reg;
          ptr_reg   <= ptr_adv;
          state_reg <= ST_IDLE;
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
